// File: rtl/phy_link_ctrl_pkg.sv
// Shared definitions for the phy link controller.
//   - Line symbols driven toward the phy (COM for training, IDL for empty lanes).
//   - Controller state encoding.
//   - Default training / buffering parameters.
//   - Helper that qualifies one rx sample as a good lock cycle.
package phy_link_ctrl_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    localparam int DEF_TRAIN_CYCLES = 16;
    localparam int DEF_LOCK_COUNT   = 4;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FAIL   = 3'd4
    } link_state_e;

    // A lock cycle needs every lane reporting valid and lane 0 echoing COM.
    function automatic logic rx_lock_ok(input logic [3:0] valid, input logic [7:0] data);
        return (valid == 4'b1111) && (data == SYM_COM);
    endfunction

endpackage

// File: rtl/phy_link_ctrl_lane_fifo.sv
// Per-lane synchronous FIFO.
//   clk1f  in   clock, all state on rising edge
//   reset  in   asynchronous active-high, empties the FIFO and clears storage
//   push   in   write din (ignored while full)
//   pop    in   drop head entry (ignored while empty)
//   din    in   WIDTH write data
//   head   out  oldest entry (valid while !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two >= 2 so that the pointers wrap naturally.
module phy_link_ctrl_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk1f,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; push and pop may both happen in one cycle.
    always_ff @(posedge clk1f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/phy_link_ctrl.sv
// Link sequencer / scheduler in front of a 4-lane phy.
//   clk1f            in   sole clock
//   reset            in   asynchronous active-high
//   enable           in   1 = train and stay up, 0 = drain then idle
//   req_data0..3     in   requester byte per lane
//   req_valid        in   per-lane requester valid
//   req_ready        out  per-lane ready (ACTIVE and FIFO not full)
//   phy_in0..3       out  registered bytes toward the phy
//   phy_validin      out  registered per-lane valid toward the phy
//   rx_out0          in   phy lane-0 receive data, used for lock detect
//   rx_validout      in   phy receive valids
//   link_up          out  registered, high only in ACTIVE
//   fail             out  registered, high only in FAIL
// Training drives COM on every lane until LOCK_COUNT consecutive good rx
// cycles are seen; each attempt lasts TRAIN_CYCLES cycles and MAX_RETRY
// failed attempts end in FAIL. Once up, each lane FIFO is popped every cycle
// it holds data; empty lanes carry IDL with valid low.
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter int TRAIN_CYCLES = DEF_TRAIN_CYCLES,
    parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk1f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [7:0] req_data2,
    input  logic [7:0] req_data3,
    input  logic [3:0] req_valid,
    output logic [3:0] req_ready,
    output logic [7:0] phy_in0,
    output logic [7:0] phy_in1,
    output logic [7:0] phy_in2,
    output logic [7:0] phy_in3,
    output logic [3:0] phy_validin,
    input  logic [7:0] rx_out0,
    input  logic [3:0] rx_validout,
    output logic       link_up,
    output logic       fail
);

    localparam int TW = $clog2(TRAIN_CYCLES);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    link_state_e          st_r;
    link_state_e          nxt_s;
    logic [TW-1:0]        train_cnt_r;
    logic [LW-1:0]        lock_cnt_r;
    logic [RW-1:0]        retry_r;
    logic                 rx_good_s;
    logic                 lock_hit_s;
    logic                 train_end_s;
    logic                 retry_last_s;
    logic                 serving_s;
    logic                 all_empty_s;
    logic [7:0]           req_data_s [NUM_LANES];
    logic [7:0]           head_s     [NUM_LANES];
    logic [NUM_LANES-1:0] full_s;
    logic [NUM_LANES-1:0] empty_s;
    logic [NUM_LANES-1:0] push_s;
    logic [NUM_LANES-1:0] pop_s;
    logic [7:0]           phy_in_r   [NUM_LANES];
    logic [NUM_LANES-1:0] phy_validin_r;
    logic                 link_up_r;
    logic                 fail_r;

    assign req_data_s[0] = req_data0;
    assign req_data_s[1] = req_data1;
    assign req_data_s[2] = req_data2;
    assign req_data_s[3] = req_data3;

    assign rx_good_s    = rx_lock_ok(rx_validout, rx_out0);
    // Lock completes on the edge that brings the run of good cycles to LOCK_COUNT.
    assign lock_hit_s   = rx_good_s && (lock_cnt_r == LW'(LOCK_COUNT - 1));
    assign train_end_s  = (train_cnt_r == TW'(TRAIN_CYCLES - 1));
    assign retry_last_s = (retry_r == RW'(MAX_RETRY - 1));

    // Lanes are served (popped) in ACTIVE and while draining.
    assign serving_s   = (st_r == ST_ACTIVE) || (st_r == ST_DRAIN);
    assign all_empty_s = &empty_s;
    assign pop_s       = serving_s ? ~empty_s : {NUM_LANES{1'b0}};
    // Ready depends only on state and occupancy, never on req_valid.
    assign req_ready   = (st_r == ST_ACTIVE) ? ~full_s : {NUM_LANES{1'b0}};
    assign push_s      = req_valid & req_ready;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        phy_link_ctrl_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (8)
        ) u_fifo (
            .clk1f (clk1f),
            .reset (reset),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   (req_data_s[g]),
            .head  (head_s[g]),
            .full  (full_s[g]),
            .empty (empty_s[g])
        );
    end

    // Controller state register.
    always_ff @(posedge clk1f or posedge reset) begin
        if (reset) begin
            st_r <= ST_IDLE;
        end else begin
            st_r <= nxt_s;
        end
    end

    // Next-state decode; disable in TRAIN wins over lock and timeout.
    always_comb begin
        nxt_s = st_r;
        case (st_r)
            ST_IDLE: begin
                if (enable) nxt_s = ST_TRAIN;
                else        nxt_s = ST_IDLE;
            end
            ST_TRAIN: begin
                if (!enable)                         nxt_s = ST_IDLE;
                else if (lock_hit_s)                 nxt_s = ST_ACTIVE;
                else if (train_end_s && retry_last_s) nxt_s = ST_FAIL;
                else                                 nxt_s = ST_TRAIN;
            end
            ST_ACTIVE: begin
                if (!enable) nxt_s = ST_DRAIN;
                else         nxt_s = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (all_empty_s) nxt_s = ST_IDLE;
                else             nxt_s = ST_DRAIN;
            end
            ST_FAIL: begin
                if (!enable) nxt_s = ST_FAIL == ST_FAIL ? ST_IDLE : ST_FAIL;
                else         nxt_s = ST_FAIL;
            end
            default: nxt_s = ST_IDLE;
        endcase
    end

    // Training counters; held at zero outside TRAIN so every entry starts clean.
    always_ff @(posedge clk1f or posedge reset) begin
        if (reset) begin
            train_cnt_r <= {TW{1'b0}};
            lock_cnt_r  <= {LW{1'b0}};
            retry_r     <= {RW{1'b0}};
        end else if (st_r != ST_TRAIN) begin
            train_cnt_r <= {TW{1'b0}};
            lock_cnt_r  <= {LW{1'b0}};
            retry_r     <= {RW{1'b0}};
        end else if (train_end_s) begin
            // Attempt timed out: restart with fresh counters.
            train_cnt_r <= {TW{1'b0}};
            lock_cnt_r  <= {LW{1'b0}};
            if (!retry_last_s) retry_r <= retry_r + RW'(1);
            else               retry_r <= retry_r;
        end else begin
            train_cnt_r <= train_cnt_r + TW'(1);
            if (!rx_good_s)                           lock_cnt_r <= {LW{1'b0}};
            else if (lock_cnt_r != LW'(LOCK_COUNT))   lock_cnt_r <= lock_cnt_r + LW'(1);
            else                                      lock_cnt_r <= lock_cnt_r;
        end
    end

    // Registered output stage, keyed on the state being entered so that
    // outputs always reflect the current state.
    always_ff @(posedge clk1f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                phy_in_r[i] <= 8'h00;
            end
            phy_validin_r <= {NUM_LANES{1'b0}};
            link_up_r     <= 1'b0;
            fail_r        <= 1'b0;
        end else begin
            case (nxt_s)
                ST_TRAIN: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        phy_in_r[i] <= SYM_COM;
                    end
                    phy_validin_r <= {NUM_LANES{1'b1}};
                end
                ST_ACTIVE, ST_DRAIN: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        phy_in_r[i] <= pop_s[i] ? head_s[i] : SYM_IDL;
                    end
                    phy_validin_r <= pop_s;
                end
                default: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        phy_in_r[i] <= 8'h00;
                    end
                    phy_validin_r <= {NUM_LANES{1'b0}};
                end
            endcase
            link_up_r <= (nxt_s == ST_ACTIVE);
            fail_r    <= (nxt_s == ST_FAIL);
        end
    end

    assign phy_in0     = phy_in_r[0];
    assign phy_in1     = phy_in_r[1];
    assign phy_in2     = phy_in_r[2];
    assign phy_in3     = phy_in_r[3];
    assign phy_validin = phy_validin_r;
    assign link_up     = link_up_r;
    assign fail        = fail_r;

endmodule
